// File: rtl/mcs51_timer_array_if.sv
// SFR bus bundle shared by the CPU side and the timer array.
`timescale 1ns/1ps
interface mcs51_timer_array_if;
    logic       mem_sel;
    logic [7:0] mem_addr;
    logic       mem_we_n;
    logic       mem_rd_n;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ready;

    modport master (
        output mem_sel, mem_addr, mem_we_n, mem_rd_n, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_sel, mem_addr, mem_we_n, mem_rd_n, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mcs51_timer_array.sv
// mcs51_timer_array: NUM_TIMERS independent 8051-style timer/counters
// (modes 0-3, gate, external events, interrupt enable, overflow strobes)
// mapped as four SFR bytes per channel on the Naive-Memory bus.
`timescale 1ns/1ps
module mcs51_timer_array #(
    parameter int         NUM_TIMERS = 2,
    parameter int         PRESCALE   = 12,
    parameter logic [7:0] BASE_ADDR  = 8'h80
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mcs51_timer_array_if.slave    bus,
    input  logic [NUM_TIMERS-1:0] t_in,
    input  logic [NUM_TIMERS-1:0] gate_in,
    input  logic [NUM_TIMERS-1:0] int_ack,
    output logic [NUM_TIMERS-1:0] irq,
    output logic [NUM_TIMERS-1:0] ovf_pulse
);
    localparam int N = NUM_TIMERS;

    // Shared prescaler
    logic [7:0]   pre_cnt;
    logic         tick;

    // Synchronisers and external event detection
    logic [N-1:0] t_meta;
    logic [N-1:0] t_sync;
    logic [N-1:0] t_last;
    logic [N-1:0] g_meta;
    logic [N-1:0] g_sync;
    logic [N-1:0] ext_event;

    // Architectural registers
    logic [7:0]   tl   [N];
    logic [7:0]   th   [N];
    logic [1:0]   mode [N];
    logic [N-1:0] ct;
    logic [N-1:0] gate;
    logic [N-1:0] tr;
    logic [N-1:0] tf;
    logic [N-1:0] ie;
    logic [N-1:0] trh;
    logic [N-1:0] tfh;

    // Counting datapath results
    logic [7:0]   tl_nxt [N];
    logic [7:0]   th_nxt [N];
    logic [N-1:0] run;
    logic [N-1:0] tf_hw;
    logic [N-1:0] tfh_hw;
    logic [N-1:0] ovf_hw;

    // Bus decode
    logic [7:0]   offset;
    logic         in_map;
    logic         wr_cyc;
    logic         rd_cyc;
    logic [N-1:0] wr_tl;
    logic [N-1:0] wr_th;
    logic [N-1:0] wr_tmod;
    logic [N-1:0] wr_tcon;
    logic [7:0]   rd_val;

    assign tick = (pre_cnt == 8'(PRESCALE - 1));

    // Free-running prescaler; tick marks the last cycle of each period
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= 8'd0;
        end else if (tick) begin
            pre_cnt <= 8'd0;
        end else begin
            pre_cnt <= pre_cnt + 8'd1;
        end
    end

    // Two-flop synchronisers for the pins; t_in is also sampled once per tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_meta <= '0;
            t_sync <= '0;
            t_last <= '0;
            g_meta <= '0;
            g_sync <= '0;
        end else begin
            t_meta <= t_in;
            t_sync <= t_meta;
            g_meta <= gate_in;
            g_sync <= g_meta;
            if (tick) begin
                t_last <= t_sync;
            end
        end
    end

    // A counted event is a 1 -> 0 change between two consecutive tick samples
    assign ext_event = t_last & ~t_sync;
    assign run       = tr & (~gate | g_sync) & {N{tick}} & (~ct | ext_event);

    assign offset = bus.mem_addr - BASE_ADDR;
    assign in_map = (bus.mem_addr >= BASE_ADDR) && (offset < 8'(4 * N));
    assign wr_cyc = bus.mem_sel & ~bus.mem_we_n;
    assign rd_cyc = bus.mem_sel & ~bus.mem_rd_n;

    // Per-channel, per-register write enables
    always_comb begin
        wr_tl   = '0;
        wr_th   = '0;
        wr_tmod = '0;
        wr_tcon = '0;
        for (int i = 0; i < N; i++) begin
            if (wr_cyc && in_map && (offset[3:2] == 2'(i))) begin
                case (offset[1:0])
                    2'd0:    wr_tl[i]   = 1'b1;
                    2'd1:    wr_th[i]   = 1'b1;
                    2'd2:    wr_tmod[i] = 1'b1;
                    default: wr_tcon[i] = 1'b1;
                endcase
            end
        end
    end

    // Read-data mux; unmapped addresses read as zero
    always_comb begin
        rd_val = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (in_map && (offset[3:2] == 2'(i))) begin
                case (offset[1:0])
                    2'd0:    rd_val = tl[i];
                    2'd1:    rd_val = th[i];
                    2'd2:    rd_val = {4'h0, gate[i], ct[i], mode[i]};
                    default: rd_val = {3'b000, tfh[i], trh[i], ie[i], tf[i], tr[i]};
                endcase
            end
        end
    end

    // Next counter values and hardware flag sets for every mode
    always_comb begin
        for (int i = 0; i < N; i++) begin
            tl_nxt[i] = tl[i];
            th_nxt[i] = th[i];
            tf_hw[i]  = 1'b0;
            tfh_hw[i] = 1'b0;
            ovf_hw[i] = 1'b0;
            case (mode[i])
                2'd0: begin
                    if (run[i]) begin
                        if ({th[i], tl[i][4:0]} == 13'h1FFF) begin
                            th_nxt[i] = 8'h00;
                            tl_nxt[i] = {tl[i][7:5], 5'h00};
                            tf_hw[i]  = 1'b1;
                            ovf_hw[i] = 1'b1;
                        end else begin
                            {th_nxt[i], tl_nxt[i][4:0]} = {th[i], tl[i][4:0]} + 13'd1;
                        end
                    end
                end
                2'd1: begin
                    if (run[i]) begin
                        {th_nxt[i], tl_nxt[i]} = {th[i], tl[i]} + 16'd1;
                        if ({th[i], tl[i]} == 16'hFFFF) begin
                            tf_hw[i]  = 1'b1;
                            ovf_hw[i] = 1'b1;
                        end
                    end
                end
                2'd2: begin
                    if (run[i]) begin
                        if (tl[i] == 8'hFF) begin
                            tl_nxt[i] = th[i];
                            tf_hw[i]  = 1'b1;
                            ovf_hw[i] = 1'b1;
                        end else begin
                            tl_nxt[i] = tl[i] + 8'd1;
                        end
                    end
                end
                default: begin
                    if (run[i]) begin
                        tl_nxt[i] = tl[i] + 8'd1;
                        if (tl[i] == 8'hFF) begin
                            tf_hw[i]  = 1'b1;
                            ovf_hw[i] = 1'b1;
                        end
                    end
                    if (trh[i] && tick) begin
                        th_nxt[i] = th[i] + 8'd1;
                        if (th[i] == 8'hFF) begin
                            tfh_hw[i] = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Register update: CPU writes beat counting, hardware flag sets beat clears
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                tl[i]   <= 8'h00;
                th[i]   <= 8'h00;
                mode[i] <= 2'd0;
            end
            ct        <= '0;
            gate      <= '0;
            tr        <= '0;
            tf        <= '0;
            ie        <= '0;
            trh       <= '0;
            tfh       <= '0;
            ovf_pulse <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                tl[i] <= wr_tl[i] ? bus.mem_wdata : tl_nxt[i];
                th[i] <= wr_th[i] ? bus.mem_wdata : th_nxt[i];
                if (wr_tmod[i]) begin
                    mode[i] <= bus.mem_wdata[1:0];
                    ct[i]   <= bus.mem_wdata[2];
                    gate[i] <= bus.mem_wdata[3];
                end
                if (wr_tcon[i]) begin
                    tr[i]  <= bus.mem_wdata[0];
                    ie[i]  <= bus.mem_wdata[2];
                    trh[i] <= bus.mem_wdata[3];
                end
                tf[i]  <= tf_hw[i]  | (wr_tcon[i] ? bus.mem_wdata[1] : (tf[i]  & ~int_ack[i]));
                tfh[i] <= tfh_hw[i] | (wr_tcon[i] ? bus.mem_wdata[4] : (tfh[i] & ~int_ack[i]));
            end
            ovf_pulse <= ovf_hw;
        end
    end

    assign irq = ie & (tf | tfh);

    // Bus response: registered read data and a one-cycle ready per access
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.mem_rdata <= 8'h00;
            bus.mem_ready <= 1'b0;
        end else begin
            bus.mem_ready <= wr_cyc | rd_cyc;
            if (rd_cyc) begin
                bus.mem_rdata <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_mcs51_timer_array.sv
// Testbench for mcs51_timer_array: bus reads are scored against a queue of
// expected bytes; strobes and interrupts are checked at the falling edge.
`timescale 1ns/1ps
module tb_mcs51_timer_array;
    localparam int N = 2;
    localparam int P = 12;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] t_in;
    logic [N-1:0] gate_in;
    logic [N-1:0] int_ack;
    logic [N-1:0] irq;
    logic [N-1:0] ovf_pulse;

    mcs51_timer_array_if bus ();

    mcs51_timer_array #(
        .NUM_TIMERS (N),
        .PRESCALE   (P),
        .BASE_ADDR  (8'h80)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .t_in      (t_in),
        .gate_in   (gate_in),
        .int_ack   (int_ack),
        .irq       (irq),
        .ovf_pulse (ovf_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] value;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   checksDone   = 0;
    int   checksPassed = 0;
    int   edges        = 0;
    logic rdAccepted;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checksDone++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Count clock edges since reset release to locate prescaler ticks
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edges <= 0;
        else          edges <= edges + 1;
    end

    // Remember which edges accepted a read so the response can be scored
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rdAccepted <= 1'b0;
        else          rdAccepted <= bus.mem_sel && !bus.mem_rd_n;
    end

    // Scoreboard: pop the oldest expected byte for every read response
    always @(negedge clk) begin
        if (rdAccepted) begin
            if (expQ.size() == 0) begin
                checkOutput("sb_unexpected_read", 8'(expQ.size()), 8'd1);
            end else begin
                monE = expQ.pop_front();
                checkOutput({monE.tag, "_ready"}, 8'(bus.mem_ready), 8'd1);
                checkOutput(monE.tag, bus.mem_rdata, monE.value);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data);
        bus.mem_sel   = 1'b1;
        bus.mem_we_n  = 1'b0;
        bus.mem_addr  = addr;
        bus.mem_wdata = data;
        @(negedge clk);
        bus.mem_sel   = 1'b0;
        bus.mem_we_n  = 1'b1;
    endtask

    task automatic readExpect(input string tag, input logic [7:0] addr, input logic [7:0] expected);
        exp_t e;
        e.tag   = tag;
        e.value = expected;
        expQ.push_back(e);
        bus.mem_sel  = 1'b1;
        bus.mem_rd_n = 1'b0;
        bus.mem_addr = addr;
        @(negedge clk);
        bus.mem_sel  = 1'b0;
        bus.mem_rd_n = 1'b1;
    endtask

    // Return at the falling edge right after the n-th following tick edge
    task automatic waitTick(input int n);
        repeat (n) begin
            do @(negedge clk); while (edges % P != 0);
        end
    endtask

    task automatic pulseAck(input int ch);
        int_ack[ch] = 1'b1;
        @(negedge clk);
        int_ack = '0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.mem_sel   = 1'b0;
        bus.mem_we_n  = 1'b1;
        bus.mem_rd_n  = 1'b1;
        bus.mem_addr  = 8'h00;
        bus.mem_wdata = 8'h00;
        t_in    = '1;
        gate_in = '0;
        int_ack = '0;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        checkOutput("rst_rdata", bus.mem_rdata, 8'h00);
        checkOutput("rst_ready", 8'(bus.mem_ready), 8'h00);
        checkOutput("rst_irq", 8'(irq), 8'h00);
        checkOutput("rst_ovf", 8'(ovf_pulse), 8'h00);
        readExpect("rst_tl0", 8'h80, 8'h00);
        readExpect("rst_tmod0", 8'h82, 8'h00);
        readExpect("rst_th1", 8'h85, 8'h00);
        readExpect("rst_tcon1", 8'h87, 8'h00);

        // Unmapped addresses
        applyStimulus(8'h88, 8'hAA);
        readExpect("oob_88", 8'h88, 8'h00);
        readExpect("oob_7f", 8'h7F, 8'h00);

        // Mode 1 overflow after exactly two ticks, IE off
        applyStimulus(8'h82, 8'h01);
        applyStimulus(8'h80, 8'hFE);
        applyStimulus(8'h81, 8'hFF);
        applyStimulus(8'h83, 8'h01);
        waitTick(1);
        checkOutput("m1_tick1_ovf", 8'(ovf_pulse[0]), 8'h00);
        waitTick(1);
        checkOutput("m1_tick2_ovf", 8'(ovf_pulse[0]), 8'h01);
        checkOutput("m1_no_irq", 8'(irq[0]), 8'h00);
        @(negedge clk);
        checkOutput("m1_ovf_width", 8'(ovf_pulse[0]), 8'h00);
        readExpect("m1_tl", 8'h80, 8'h00);
        readExpect("m1_th", 8'h81, 8'h00);
        readExpect("m1_tcon", 8'h83, 8'h03);
        applyStimulus(8'h83, 8'h06);
        checkOutput("m1_irq_ie", 8'(irq[0]), 8'h01);
        pulseAck(0);
        checkOutput("m1_ack_irq", 8'(irq[0]), 8'h00);
        applyStimulus(8'h83, 8'h14);
        checkOutput("sw_tfh_irq", 8'(irq[0]), 8'h01);
        readExpect("sw_tcon", 8'h83, 8'h14);
        applyStimulus(8'h83, 8'h00);
        checkOutput("sw_clear_irq", 8'(irq[0]), 8'h00);

        // Mode 2 auto-reload on channel 1
        applyStimulus(8'h86, 8'h02);
        applyStimulus(8'h85, 8'hF0);
        applyStimulus(8'h84, 8'hFF);
        applyStimulus(8'h87, 8'h05);
        waitTick(1);
        checkOutput("m2_ovf1", 8'(ovf_pulse[1]), 8'h01);
        checkOutput("m2_irq1", 8'(irq[1]), 8'h01);
        readExpect("m2_reload", 8'h84, 8'hF0);
        pulseAck(1);
        checkOutput("m2_ack_irq", 8'(irq[1]), 8'h00);
        readExpect("m2_tcon_acked", 8'h87, 8'h05);
        waitTick(15);
        checkOutput("m2_tick15_ovf", 8'(ovf_pulse[1]), 8'h00);
        readExpect("m2_tl_ff", 8'h84, 8'hFF);
        waitTick(1);
        checkOutput("m2_ovf2", 8'(ovf_pulse[1]), 8'h01);
        checkOutput("m2_irq2", 8'(irq[1]), 8'h01);
        readExpect("m2_reload2", 8'h84, 8'hF0);
        readExpect("m2_th_kept", 8'h85, 8'hF0);
        applyStimulus(8'h87, 8'h00);

        // Mode 0 13-bit wrap keeps TL[7:5]
        applyStimulus(8'h86, 8'h00);
        applyStimulus(8'h84, 8'hFF);
        applyStimulus(8'h85, 8'hFF);
        applyStimulus(8'h87, 8'h01);
        waitTick(1);
        checkOutput("m0_ovf", 8'(ovf_pulse[1]), 8'h01);
        readExpect("m0_tl", 8'h84, 8'hE0);
        readExpect("m0_th", 8'h85, 8'h00);
        readExpect("m0_tcon", 8'h87, 8'h03);
        applyStimulus(8'h87, 8'h00);

        // Gate control on channel 0
        applyStimulus(8'h82, 8'h09);
        applyStimulus(8'h80, 8'h00);
        applyStimulus(8'h81, 8'h00);
        applyStimulus(8'h83, 8'h01);
        waitTick(10);
        readExpect("gate_hold", 8'h80, 8'h00);
        gate_in[0] = 1'b1;
        waitTick(1);
        readExpect("gate_resume", 8'h80, 8'h01);
        applyStimulus(8'h83, 8'h00);
        gate_in[0] = 1'b0;

        // External event counting: five falling edges
        applyStimulus(8'h82, 8'h05);
        applyStimulus(8'h80, 8'h00);
        applyStimulus(8'h81, 8'h00);
        applyStimulus(8'h83, 8'h01);
        for (int k = 0; k < 5; k++) begin
            t_in[0] = 1'b0;
            waitTick(3);
            t_in[0] = 1'b1;
            waitTick(3);
        end
        readExpect("ct_tl", 8'h80, 8'h05);
        readExpect("ct_th", 8'h81, 8'h00);
        applyStimulus(8'h83, 8'h00);

        // Mode 3 split: TH on TRH only, TL idle
        applyStimulus(8'h86, 8'h03);
        applyStimulus(8'h84, 8'h33);
        applyStimulus(8'h85, 8'hFF);
        applyStimulus(8'h87, 8'h08);
        waitTick(1);
        checkOutput("m3_no_ovf", 8'(ovf_pulse[1]), 8'h00);
        checkOutput("m3_no_irq", 8'(irq[1]), 8'h00);
        readExpect("m3_tcon", 8'h87, 8'h18);
        readExpect("m3_tl", 8'h84, 8'h33);
        readExpect("m3_th", 8'h85, 8'h00);
        applyStimulus(8'h87, 8'h1C);
        checkOutput("m3_irq_ie", 8'(irq[1]), 8'h01);
        applyStimulus(8'h87, 8'h00);
        checkOutput("m3_irq_clr", 8'(irq[1]), 8'h00);

        // Collisions: CPU TL write on a tick, hardware TF set against CPU clear
        applyStimulus(8'h82, 8'h01);
        applyStimulus(8'h80, 8'h10);
        applyStimulus(8'h81, 8'h00);
        applyStimulus(8'h83, 8'h01);
        waitTick(1);
        repeat (11) @(negedge clk);
        applyStimulus(8'h80, 8'h55);
        readExpect("col_tl_write", 8'h80, 8'h55);
        readExpect("col_th", 8'h81, 8'h00);
        waitTick(1);
        applyStimulus(8'h81, 8'hFF);
        applyStimulus(8'h80, 8'hFF);
        repeat (9) @(negedge clk);
        applyStimulus(8'h83, 8'h01);
        checkOutput("col_ovf", 8'(ovf_pulse[0]), 8'h01);
        readExpect("col_tf_wins", 8'h83, 8'h03);
        readExpect("col_tl_wrap", 8'h80, 8'h00);

        // Asynchronous reset mid-count
        applyStimulus(8'h83, 8'h07);
        checkOutput("pre_rst_irq", 8'(irq[0]), 8'h01);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("arst_irq", 8'(irq), 8'h00);
        checkOutput("arst_ovf", 8'(ovf_pulse), 8'h00);
        checkOutput("arst_ready", 8'(bus.mem_ready), 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        readExpect("arst_tcon", 8'h83, 8'h00);
        readExpect("arst_tl", 8'h80, 8'h00);

        for (int k = 0; k < 10 && expQ.size() != 0; k++) @(negedge clk);
        checkOutput("sb_drain", 8'(expQ.size()), 8'h00);

        $display("%0d/%0d checks passed", checksPassed, checksDone);
        $finish;
    end

endmodule

// File: doc/mcs51_timer_array.md
# mcs51_timer_array

Parametrised 8051-compatible timer/counter array for the MCS-51 peripheral subsystem, replacing the fixed two-timer logic in the basic peripheral block. It provides NUM_TIMERS independent 16-bit timer/counters with modes 0-3, gate control, external event counting, per-channel interrupt enable, and single-cycle overflow strobes for the UART baud generator. It sits on the Naive-Memory SFR bus beside the UART and IO-port blocks.

## Interface
- NUM_TIMERS, 2, channel count, 1..4
- PRESCALE, 12, internal tick divider (clk cycles per tick), 2..255
- BASE_ADDR, 8'h80, SFR base; channel i occupies BASE_ADDR+4i .. +4i+3
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- mem_sel  in  1  bus cycle valid
- mem_addr  in  8  SFR address
- mem_we_n  in  1  write strobe, active-low
- mem_rd_n  in  1  read strobe, active-low
- mem_wdata  in  8  write data
- mem_rdata  out  8  registered read data
- mem_ready  out  1  read data valid / write accepted
- t_in  in  NUM_TIMERS  external count pins (T0/T1…), asynchronous
- gate_in  in  NUM_TIMERS  gate pins (INT0/INT1…), asynchronous
- int_ack  in  NUM_TIMERS  interrupt-vector acknowledge, one cycle, clears TF_i and TFH_i
- irq  out  NUM_TIMERS  interrupt request per channel
- ovf_pulse  out  NUM_TIMERS  one-cycle strobe on every TL/16-bit overflow

## Operation
- Register map, channel i: +0 TL_i, +1 TH_i, +2 TMOD_i ([1:0] M, [2] C/T, [3] GATE), +3 TCON_i ([0] TR, [1] TF, [2] IE, [3] TRH, [4] TFH, [7:5] read 0).
- Addresses outside the map: writes ignored, reads return 8'h00, mem_ready still asserted.
- Prescaler: free-running counter 0..PRESCALE-1; tick = counter==PRESCALE-1.
- t_in/gate_in: 2-FF synchronised. When C/T=1, the event is a 1→0 transition of synchronised t_in sampled at consecutive ticks (max rate one per 2 ticks).
- run_i = TR_i & (~GATE_i | gate_sync_i) & (C/T ? event_i : tick).
- Modes (counting only when run_i):
  - M=0: 13-bit counter {TH, TL[4:0]}; TL[7:5] held; 0x1FFF→0 sets TF, pulses ovf.
  - M=1: 16-bit {TH,TL}; 0xFFFF→0 sets TF, pulses ovf.
  - M=2: TL 8-bit, TL==0xFF → TL=TH, sets TF, pulses ovf; TH unchanged.
  - M=3: TL behaves as 8-bit free counter (0xFF→0, TF, ovf); TH counts internal ticks when TRH & tick (ignores C/T, GATE), 0xFF→0 sets TFH (no ovf pulse).
- irq_i = IE_i & (TF_i | TFH_i).
- Collisions: CPU write to TL/TH wins over same-cycle increment/reload (count lost). Hardware set of TF/TFH wins over same-cycle CPU write-0 or int_ack. CPU write 1 to TF/TFH sets it (software interrupt).
- Changing M mid-count: counter value kept, new mode applies from next tick.

## Timing
- Reset: all TL/TH/TMOD/TCON = 0, prescaler = 0, sync FFs = 0, mem_rdata = 0, mem_ready = 0, irq = 0, ovf_pulse = 0.
- First tick PRESCALE cycles after reset release, then every PRESCALE cycles.
- Increment, reload, and TF set occur on the clk edge ending the tick cycle; irq rises the same edge; ovf_pulse high exactly the following cycle.
- External input: t_in falling edge to count ≤ 2 sync cycles + 2 ticks.
- Bus: write commits on the edge where mem_sel & ~mem_we_n; read data registered on the edge where mem_sel & ~mem_rd_n; mem_ready high for one cycle after each accepted access (latency 1, no back-pressure).
- Reset assertion mid-count immediately clears all state asynchronously; no pulse or irq emitted.

## Test plan
- M=1, TL=0xFE, TH=0xFF, TR=1, PRESCALE=12 → TF and ovf_pulse after exactly 2 ticks (24 cycles), counter = 0x0000, irq only if IE=1.
- M=2, TH=0xF0, TL=0xFF, run → next tick TL=0xF0, TF=1; 16 further ticks give second overflow; int_ack clears TF, irq drops next cycle.
- GATE=1, gate_in=0 for 10 ticks → no counting; gate_in=1 → counting resumes within 2 sync cycles + 1 tick.
- C/T=1, 5 t_in pulses each 3 ticks wide → TL increments by exactly 5.
- M=3, TRH=1, TR=0, TH=0xFF → TFH after 1 tick, TL unchanged, no ovf_pulse.
- Same-cycle CPU write TL=0x55 with increment → TL reads 0x55; same-cycle TF set and CPU clear → TF reads 1.
